// File: rtl/sha256_core.sv
// Single-block SHA-256 compression engine: one round per clock from the fixed IV,
// digest presented with a one-cycle Done pulse.
module sha256_core (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         Start,
   input  logic [511:0] Block,
   output logic [255:0] Digest,
   output logic         Done,
   output logic         Busy
);

   localparam int unsigned WORD_W = 32;
   localparam int unsigned CNT_W  = 6;

   localparam logic [255:0] IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   localparam logic [WORD_W-1:0] K_TAB [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_t;

   function automatic logic [WORD_W-1:0] f_bsig0(input logic [WORD_W-1:0] x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction

   function automatic logic [WORD_W-1:0] f_bsig1(input logic [WORD_W-1:0] x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction

   function automatic logic [WORD_W-1:0] f_ssig0(input logic [WORD_W-1:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [WORD_W-1:0] f_ssig1(input logic [WORD_W-1:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_t;
   logic [WORD_W-1:0]   r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
   logic [WORD_W-1:0]   r_w [0:15];
   logic [255:0]        r_digest;
   logic                r_done;
   logic                r_busy;

   logic [WORD_W-1:0]   w_t1;
   logic [WORD_W-1:0]   w_t2;
   logic [WORD_W-1:0]   w_wnew;

   // Round datapath; r_w[0] always holds W[t], r_w[15] receives W[t+16]
   assign w_t1   = r_h + f_bsig1(r_e) + ((r_e & r_f) ^ (~r_e & r_g)) + K_TAB[r_t] + r_w[0];
   assign w_t2   = f_bsig0(r_a) + ((r_a & r_b) ^ (r_a & r_c) ^ (r_b & r_c));
   assign w_wnew = f_ssig1(r_w[14]) + r_w[9] + f_ssig0(r_w[1]) + r_w[0];

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (Start) w_state_nxt = S_ROUND;
         S_ROUND: if (r_t == CNT_W'(63)) w_state_nxt = S_FINAL;
         S_FINAL: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         r_t      <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_c      <= '0;
         r_d      <= '0;
         r_e      <= '0;
         r_f      <= '0;
         r_g      <= '0;
         r_h      <= '0;
         for (int i = 0; i < 16; i++) r_w[i] <= '0;
         r_digest <= '0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (Start) begin
                  for (int i = 0; i < 16; i++) r_w[i] <= Block[511 - 32*i -: 32];
                  {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= IV;
                  r_t    <= '0;
                  r_busy <= 1'b1;
               end
            end
            S_ROUND: begin
               r_h <= r_g;
               r_g <= r_f;
               r_f <= r_e;
               r_e <= r_d + w_t1;
               r_d <= r_c;
               r_c <= r_b;
               r_b <= r_a;
               r_a <= w_t1 + w_t2;
               for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
               r_w[15] <= w_wnew;
               r_t     <= r_t + CNT_W'(1);
            end
            S_FINAL: begin
               r_digest <= {IV[255:224] + r_a, IV[223:192] + r_b, IV[191:160] + r_c, IV[159:128] + r_d,
                            IV[127:96]  + r_e, IV[95:64]    + r_f, IV[63:32]    + r_g, IV[31:0]     + r_h};
               r_done   <= 1'b1;
               r_busy   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign Digest = r_digest;
   assign Done   = r_done;
   assign Busy   = r_busy;

endmodule

// File: tb/tb_sha256_core.sv
// Scoreboard bench for sha256_core: directed FIPS vectors plus random blocks checked
// against an array-based SHA-256 model.
module tb_sha256_core;

   logic         Clk = 1'b0;
   logic         Reset;
   logic         Start;
   logic [511:0] Block;
   logic [255:0] Digest;
   logic         Done;
   logic         Busy;

   sha256_core dut (
      .Clk    (Clk),
      .Reset  (Reset),
      .Start  (Start),
      .Block  (Block),
      .Digest (Digest),
      .Done   (Done),
      .Busy   (Busy)
   );

   always #5 Clk = ~Clk;

   localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};
   localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   localparam logic [31:0] HIV [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

   typedef struct {
      logic [255:0] dig;
      int unsigned  at;
      string        name;
   } exp_t;

   exp_t         sb[$];
   int           n_tests = 0;
   int           n_fail  = 0;
   int unsigned  cyc     = 0;
   logic [255:0] hold_val = '0;

   always @(posedge Clk) cyc <= cyc + 1;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Straight FIPS 180-4 compression over a full 64-entry schedule array
   function automatic logic [255:0] sha_ref(input logic [511:0] blk);
      logic [31:0] w[64];
      logic [31:0] v[8];
      logic [31:0] t1, t2, s0, s1;
      for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
      for (int t = 16; t < 64; t++) begin
         s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
         s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
         w[t] = s1 + w[t-7] + s0 + w[t-16];
      end
      for (int j = 0; j < 8; j++) v[j] = HIV[j];
      for (int t = 0; t < 64; t++) begin
         t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
              + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
         t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
              + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int j = 7; j > 0; j--) v[j] = v[j-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      return {HIV[0] + v[0], HIV[1] + v[1], HIV[2] + v[2], HIV[3] + v[3],
              HIV[4] + v[4], HIV[5] + v[5], HIV[6] + v[6], HIV[7] + v[7]};
   endfunction

   function automatic logic [511:0] rand_blk();
      logic [511:0] b;
      for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
      return b;
   endfunction

   // Monitor: Done pops the scoreboard; otherwise Digest must hold and Busy track the queue
   always @(negedge Clk) begin
      if (Reset) begin
         hold_val = '0;
      end else begin
         logic busy_exp;
         exp_t e;
         busy_exp = 1'b0;
         foreach (sb[i]) if (cyc + 65 >= sb[i].at && cyc < sb[i].at) busy_exp = 1'b1;
         n_tests++;
         if (Busy !== busy_exp) begin
            n_fail++;
            $display("FAIL busy cyc=%0d got=%b want=%b", cyc, Busy, busy_exp);
         end
         if (Done) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL spurious_done cyc=%0d digest=%h (no hash pending)", cyc, Digest);
            end else begin
               e = sb.pop_front();
               n_tests++;
               if (Digest !== e.dig) begin
                  n_fail++;
                  $display("FAIL digest_%s cyc=%0d got=%h want=%h", e.name, cyc, Digest, e.dig);
               end
               n_tests++;
               if (cyc != e.at) begin
                  n_fail++;
                  $display("FAIL latency_%s got_cycle=%0d want_cycle=%0d", e.name, cyc, e.at);
               end
            end
            hold_val = Digest;
         end else begin
            n_tests++;
            if (Digest !== hold_val) begin
               n_fail++;
               $display("FAIL digest_hold cyc=%0d got=%h want=%h", cyc, Digest, hold_val);
            end
         end
      end
   end

   task automatic push_exp(input logic [255:0] d, input int unsigned at, input string nm);
      exp_t e;
      e.dig  = d;
      e.at   = at;
      e.name = nm;
      sb.push_back(e);
   endtask

   // One-cycle Start pulse; Block is scrambled afterwards to prove it was captured
   task automatic issue(input logic [511:0] b, input logic [255:0] d, input string nm);
      @(negedge Clk);
      Start = 1'b1;
      Block = b;
      push_exp(d, cyc + 1 + 65, nm);
      @(negedge Clk);
      Start = 1'b0;
      Block = rand_blk();
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge Clk);
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout pending=%0d want=0", sb.size());
         sb.delete();
      end
   endtask

   task automatic check_val(input string nm, input logic [255:0] got, input logic [255:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got=%h want=%h", nm, got, want);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [511:0] b;
      int           i;
      Reset = 1'b1;
      Start = 1'b0;
      Block = '0;
      #1;
      check_val("reset_digest", Digest, '0);
      check_val("reset_done", 256'(Done), '0);
      check_val("reset_busy", 256'(Busy), '0);
      repeat (3) @(negedge Clk);
      Reset = 1'b0;

      issue(ABC_BLK, ABC_DIG, "abc");
      drain();
      issue(EMPTY_BLK, EMPTY_DIG, "empty");
      drain();

      // Start with a different block mid-hash must be ignored
      issue(ABC_BLK, ABC_DIG, "abc_ignore");
      repeat (30) @(negedge Clk);
      Start = 1'b1;
      Block = EMPTY_BLK;
      @(negedge Clk);
      Start = 1'b0;
      drain();
      repeat (70) @(negedge Clk);

      // Back-to-back: Start in the Done cycle
      issue(ABC_BLK, ABC_DIG, "b2b_abc");
      i = 0;
      while (!Done && i < 200) begin
         @(negedge Clk);
         i++;
      end
      n_tests++;
      if (!Done) begin
         n_fail++;
         $display("FAIL b2b_wait_done got=0 want=1");
      end else begin
         Start = 1'b1;
         Block = EMPTY_BLK;
         push_exp(EMPTY_DIG, cyc + 1 + 65, "b2b_empty");
         @(negedge Clk);
         Start = 1'b0;
         Block = rand_blk();
      end
      drain();

      // Reset at round 40
      issue(ABC_BLK, ABC_DIG, "rst_abort");
      repeat (41) @(negedge Clk);
      #2;
      Reset = 1'b1;
      sb.delete();
      #1;
      check_val("midrst_busy", 256'(Busy), '0);
      check_val("midrst_done", 256'(Done), '0);
      check_val("midrst_digest", Digest, '0);
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      issue(ABC_BLK, ABC_DIG, "abc_after_rst");
      drain();

      // Start held high: one hash per 66 cycles
      b = rand_blk();
      @(negedge Clk);
      Start = 1'b1;
      Block = b;
      push_exp(sha_ref(b), cyc + 1 + 65, "held_1");
      push_exp(sha_ref(b), cyc + 1 + 66 + 65, "held_2");
      repeat (67) @(negedge Clk);
      Start = 1'b0;
      drain();

      for (int k = 0; k < 8; k++) begin
         b = rand_blk();
         issue(b, sha_ref(b), $sformatf("rand%0d", k));
         for (int c = 0; c < 10; c++) begin
            @(negedge Clk);
            Block = rand_blk();
         end
         drain();
         repeat ($urandom_range(3, 0)) @(negedge Clk);
      end

      repeat (80) @(negedge Clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
